// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate L1 data cache.
// A hit completes in the request cycle. A miss stalls while an optional dirty victim is written back and the line is refilled.
module dcache_controller #(
  parameter int unsigned INDEX_BITS = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [31:0]  cpu_addr_i,
  input  logic [31:0]  cpu_data_i,
  input  logic         cpu_MemRead_i,
  input  logic         cpu_MemWrite_i,
  output logic [31:0]  cpu_data_o,
  output logic         cpu_stall_o,
  input  logic [255:0] mem_data_i,
  input  logic         mem_ack_i,
  output logic [255:0] mem_data_o,
  output logic [31:0]  mem_addr_o,
  output logic         mem_enable_o,
  output logic         mem_write_o
);

  localparam int unsigned LINES  = 1 << INDEX_BITS;
  localparam int unsigned TAG_W  = 32 - 5 - INDEX_BITS;
  localparam int unsigned LINE_W = 256;
  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITEBACK,
    S_REFILL,
    S_FILL
  } state_e;

  state_e              state_q, state_d;
  logic [LINES-1:0]    valid_q, valid_d;
  logic [LINES-1:0]    dirty_q, dirty_d;
  logic [TAG_W-1:0]    tag_q  [LINES];
  logic [LINE_W-1:0]   line_q [LINES];

  logic                mem_enable_q, mem_enable_d;
  logic                mem_write_q,  mem_write_d;
  logic [31:0]         mem_addr_q,   mem_addr_d;
  logic [LINE_W-1:0]   mem_data_q,   mem_data_d;

  logic [TAG_W-1:0]    req_tag;
  logic [INDEX_BITS-1:0] req_idx;
  logic [2:0]          req_word;
  logic [LINE_W-1:0]   cur_line;
  logic [TAG_W-1:0]    cur_tag;
  logic                req;
  logic                hit;
  logic                idle_hit;
  logic                addr_unused;

  logic                line_we;
  logic                tag_we;
  logic [LINE_W-1:0]   line_wdata;

  // Address decomposition; byte offset within a word is not used by word accesses.
  assign req_tag     = cpu_addr_i[31 -: TAG_W];
  assign req_idx     = cpu_addr_i[5 +: INDEX_BITS];
  assign req_word    = cpu_addr_i[4:2];
  assign addr_unused = ^cpu_addr_i[1:0];

  assign cur_line = line_q[req_idx];
  assign cur_tag  = tag_q[req_idx];
  assign req      = cpu_MemRead_i | cpu_MemWrite_i;
  assign hit      = valid_q[req_idx] & (cur_tag == req_tag);
  assign idle_hit = (state_q == S_IDLE) & hit;

  assign cpu_stall_o = rst_i & req & ~idle_hit;
  assign cpu_data_o  = (rst_i & idle_hit & cpu_MemRead_i & ~cpu_MemWrite_i)
                       ? cur_line[{req_word, 5'd0} +: WORD_W] : '0;

  assign mem_enable_o = mem_enable_q;
  assign mem_write_o  = mem_write_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_data_o   = mem_data_q;

  // Next-state, line update and memory-request decode.
  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    mem_enable_d = mem_enable_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    line_we      = 1'b0;
    tag_we       = 1'b0;
    line_wdata   = cur_line;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (hit) begin
            if (cpu_MemWrite_i) begin
              line_wdata[{req_word, 5'd0} +: WORD_W] = cpu_data_i;
              line_we          = 1'b1;
              dirty_d[req_idx] = 1'b1;
            end
          end else if (valid_q[req_idx] & dirty_q[req_idx]) begin
            state_d      = S_WRITEBACK;
            mem_enable_d = 1'b1;
            mem_write_d  = 1'b1;
            mem_addr_d   = {cur_tag, req_idx, 5'd0};
            mem_data_d   = cur_line;
          end else begin
            state_d      = S_REFILL;
            mem_enable_d = 1'b1;
            mem_write_d  = 1'b0;
            mem_addr_d   = {req_tag, req_idx, 5'd0};
          end
        end
      end
      S_WRITEBACK: begin
        // Enable stays high into the refill; only write and address change.
        if (mem_ack_i) begin
          state_d     = S_REFILL;
          mem_write_d = 1'b0;
          mem_addr_d  = {req_tag, req_idx, 5'd0};
        end
      end
      S_REFILL: begin
        if (mem_ack_i) begin
          state_d      = S_FILL;
          mem_enable_d = 1'b0;
        end
      end
      S_FILL: begin
        // Memory registers its read data on the ack edge, so it is valid here.
        line_wdata       = mem_data_i;
        line_we          = 1'b1;
        tag_we           = 1'b1;
        valid_d[req_idx] = 1'b1;
        dirty_d[req_idx] = 1'b0;
        state_d          = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= S_IDLE;
      valid_q      <= '0;
      dirty_q      <= '0;
      mem_enable_q <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      dirty_q      <= dirty_d;
      mem_enable_q <= mem_enable_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
    end
  end

  // Line and tag storage carry no reset; the valid bits qualify their contents.
  always_ff @(posedge clk_i) begin
    if (line_we) line_q[req_idx] <= line_wdata;
    if (tag_we)  tag_q[req_idx]  <= req_tag;
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Testbench for dcache_controller: 10-cycle line memory responder plus a flat word-memory reference model.
module tb_dcache_controller;

  logic         clk_i;
  logic         rst_i;
  logic [31:0]  cpu_addr_i;
  logic [31:0]  cpu_data_i;
  logic         cpu_MemRead_i;
  logic         cpu_MemWrite_i;
  logic [31:0]  cpu_data_o;
  logic         cpu_stall_o;
  logic [255:0] mem_data_i;
  logic         mem_ack_i;
  logic [255:0] mem_data_o;
  logic [31:0]  mem_addr_o;
  logic         mem_enable_o;
  logic         mem_write_o;

  dcache_controller #(.INDEX_BITS(4)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .cpu_addr_i     (cpu_addr_i),
    .cpu_data_i     (cpu_data_i),
    .cpu_MemRead_i  (cpu_MemRead_i),
    .cpu_MemWrite_i (cpu_MemWrite_i),
    .cpu_data_o     (cpu_data_o),
    .cpu_stall_o    (cpu_stall_o),
    .mem_data_i     (mem_data_i),
    .mem_ack_i      (mem_ack_i),
    .mem_data_o     (mem_data_o),
    .mem_addr_o     (mem_addr_o),
    .mem_enable_o   (mem_enable_o),
    .mem_write_o    (mem_write_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Initial memory image; word address 0x10 (byte 0x40) holds a known pattern.
  function automatic logic [31:0] init_word(input logic [31:0] wa);
    if (wa == 32'h10) return 32'h1111_1111;
    return (wa * 32'h9E37_79B1) ^ 32'h5A5A_3C3C;
  endfunction

  // ---------------- memory responder ----------------
  logic [255:0] line_store [int unsigned];
  logic         busy;
  int           cnt;
  logic         m_write;
  logic [31:0]  m_addr;
  logic [255:0] m_wdata;
  logic         tx_w [$];
  logic [31:0]  tx_a [$];
  logic [255:0] tx_d [$];
  int           en_rises = 0;
  logic         en_prev;

  function automatic logic [255:0] mem_line_read(input logic [31:0] a);
    logic [255:0] l;
    if (line_store.exists(a)) return line_store[a];
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = init_word((a >> 2) + 32'(i));
    return l;
  endfunction

  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      busy       <= 1'b0;
      cnt        <= 0;
      mem_ack_i  <= 1'b0;
      mem_data_i <= '0;
      en_prev    <= 1'b0;
    end else begin
      en_prev <= mem_enable_o;
      if (mem_enable_o && !en_prev) en_rises <= en_rises + 1;
      if (mem_ack_i) begin
        mem_ack_i <= 1'b0;
        busy      <= 1'b0;
        if (m_write) line_store[m_addr] = m_wdata;
        else mem_data_i <= mem_line_read(m_addr);
      end else if (busy) begin
        if (cnt == 9) mem_ack_i <= 1'b1;
        else cnt <= cnt + 1;
      end else if (mem_enable_o) begin
        busy    <= 1'b1;
        cnt     <= 1;
        m_write <= mem_write_o;
        m_addr  <= mem_addr_o;
        m_wdata <= mem_data_o;
        tx_w.push_back(mem_write_o);
        tx_a.push_back(mem_addr_o);
        tx_d.push_back(mem_data_o);
      end
    end
  end

  function automatic logic [31:0] tx_addr_at(input int k);
    if (tx_a.size() > k) return tx_a[k];
    return 'x;
  endfunction
  function automatic logic tx_write_at(input int k);
    if (tx_w.size() > k) return tx_w[k];
    return 1'bx;
  endfunction
  function automatic logic [255:0] tx_data_at(input int k);
    if (tx_d.size() > k) return tx_d[k];
    return 'x;
  endfunction

  // ---------------- reference model ----------------
  logic [31:0]  ref_word [int unsigned];
  bit           m_valid [16];
  bit           m_dirty [16];
  int unsigned  m_tag   [16];
  int           exp_stall;
  int           exp_ntx;
  logic [31:0]  exp_rdata;
  logic [31:0]  exp_vaddr;
  logic [255:0] exp_vline;

  function automatic logic [31:0] arch_word(input logic [31:0] a);
    if (ref_word.exists(a >> 2)) return ref_word[a >> 2];
    return init_word(a >> 2);
  endfunction

  function automatic logic [255:0] arch_line(input logic [31:0] a);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = arch_word(a + 32'(4 * i));
    return l;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
      m_tag[i]   = 0;
    end
  endtask

  task automatic model_access(input logic wr, input logic [31:0] addr, input logic [31:0] data);
    int unsigned idx;
    int unsigned tag;
    idx = (addr >> 5) % 16;
    tag = addr >> 9;
    exp_vaddr = '0;
    exp_vline = '0;
    if (m_valid[idx] && m_tag[idx] == tag) begin
      exp_stall = 0;
      exp_ntx   = 0;
    end else begin
      if (m_valid[idx] && m_dirty[idx]) begin
        exp_stall = 24;
        exp_ntx   = 2;
        exp_vaddr = (m_tag[idx] << 9) | (idx << 5);
        exp_vline = arch_line(exp_vaddr);
      end else begin
        exp_stall = 13;
        exp_ntx   = 1;
      end
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tag;
      m_dirty[idx] = 1'b0;
    end
    if (wr) begin
      ref_word[addr >> 2] = data;
      m_dirty[idx] = 1'b1;
      exp_rdata = '0;
    end else begin
      exp_rdata = arch_word(addr);
    end
  endtask

  // ---------------- CPU driver ----------------
  int          obs_stall;
  logic [31:0] obs_rdata;
  int          tx_base;
  int          rise_base;

  task automatic issue(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk_i);
    cpu_addr_i     = addr;
    cpu_data_i     = data;
    cpu_MemRead_i  = rd;
    cpu_MemWrite_i = wr;
    tx_base   = tx_a.size();
    rise_base = en_rises;
    obs_stall = 0;
    #1;
    while (cpu_stall_o === 1'b1 && obs_stall < 100) begin
      obs_stall++;
      @(negedge clk_i);
      #1;
    end
    total_cnt++;
    if (cpu_stall_o !== 1'b0)
      $display("FAIL issue_complete addr=%h stall=%b required 0 within 100 cycles", addr, cpu_stall_o);
    else pass_cnt++;
    obs_rdata = cpu_data_o;
    @(posedge clk_i);
    #1;
    cpu_MemRead_i  = 1'b0;
    cpu_MemWrite_i = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_i = 1'b0;
    cpu_addr_i = '0; cpu_data_i = '0; cpu_MemRead_i = 1'b0; cpu_MemWrite_i = 1'b0;
    model_reset();
    repeat (3) @(negedge clk_i);
    #1;
    total_cnt++; if (cpu_stall_o !== 1'b0) $display("FAIL reset_stall got %b expected 0", cpu_stall_o); else pass_cnt++;
    total_cnt++; if (cpu_data_o !== 32'h0) $display("FAIL reset_cpu_data got %h expected 0", cpu_data_o); else pass_cnt++;
    total_cnt++; if ({mem_enable_o, mem_write_o} !== 2'b00) $display("FAIL reset_mem_ctl got %b expected 00", {mem_enable_o, mem_write_o}); else pass_cnt++;
    total_cnt++; if (mem_addr_o !== 32'h0 || mem_data_o !== 256'h0) $display("FAIL reset_mem_bus got addr=%h data=%h expected 0", mem_addr_o, mem_data_o); else pass_cnt++;
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    #1;
    total_cnt++; if (mem_enable_o !== 1'b0 || cpu_stall_o !== 1'b0) $display("FAIL idle_no_req got en=%b stall=%b expected 0 0", mem_enable_o, cpu_stall_o); else pass_cnt++;
  endtask

  task automatic test_clean_miss();
    model_access(1'b0, 32'h40, 32'h0);
    issue(1'b1, 1'b0, 32'h40, 32'h0);
    total_cnt++; if (obs_stall !== 13) $display("FAIL clean_stall got %0d expected 13", obs_stall); else pass_cnt++;
    total_cnt++; if (obs_rdata !== 32'h1111_1111) $display("FAIL clean_rdata got %h expected 11111111", obs_rdata); else pass_cnt++;
    total_cnt++; if (tx_a.size() - tx_base !== 1) $display("FAIL clean_ntx got %0d expected 1", tx_a.size() - tx_base); else pass_cnt++;
    total_cnt++; if ({tx_write_at(tx_base), tx_addr_at(tx_base)} !== {1'b0, 32'h40}) $display("FAIL clean_tx got w=%b a=%h expected w=0 a=00000040", tx_write_at(tx_base), tx_addr_at(tx_base)); else pass_cnt++;
  endtask

  task automatic test_store_hit();
    model_access(1'b1, 32'h44, 32'hDEAD_BEEF);
    issue(1'b0, 1'b1, 32'h44, 32'hDEAD_BEEF);
    total_cnt++; if (obs_stall !== 0) $display("FAIL sthit_stall got %0d expected 0", obs_stall); else pass_cnt++;
    total_cnt++; if (en_rises - rise_base !== 0) $display("FAIL sthit_mem_enable got %0d rises expected 0", en_rises - rise_base); else pass_cnt++;
    model_access(1'b0, 32'h44, 32'h0);
    issue(1'b1, 1'b0, 32'h44, 32'h0);
    total_cnt++; if (obs_rdata !== 32'hDEAD_BEEF || obs_stall !== 0) $display("FAIL sthit_reload got %h stall=%0d expected deadbeef stall=0", obs_rdata, obs_stall); else pass_cnt++;
    model_access(1'b0, 32'h40, 32'h0);
    issue(1'b1, 1'b0, 32'h40, 32'h0);
    total_cnt++; if (obs_rdata !== 32'h1111_1111) $display("FAIL sthit_neighbour got %h expected 11111111", obs_rdata); else pass_cnt++;
  endtask

  task automatic test_dirty_miss();
    logic [255:0] wb;
    model_access(1'b0, 32'h240, 32'h0);
    issue(1'b1, 1'b0, 32'h240, 32'h0);
    wb = tx_data_at(tx_base);
    total_cnt++; if (obs_stall !== 24) $display("FAIL dirty_stall got %0d expected 24", obs_stall); else pass_cnt++;
    total_cnt++; if (tx_a.size() - tx_base !== 2) $display("FAIL dirty_ntx got %0d expected 2", tx_a.size() - tx_base); else pass_cnt++;
    total_cnt++; if ({tx_write_at(tx_base), tx_addr_at(tx_base)} !== {1'b1, 32'h40}) $display("FAIL dirty_wb_addr got w=%b a=%h expected w=1 a=00000040", tx_write_at(tx_base), tx_addr_at(tx_base)); else pass_cnt++;
    total_cnt++; if (wb[63:32] !== 32'hDEAD_BEEF || wb !== exp_vline) $display("FAIL dirty_wb_data got %h expected %h", wb, exp_vline); else pass_cnt++;
    total_cnt++; if ({tx_write_at(tx_base + 1), tx_addr_at(tx_base + 1)} !== {1'b0, 32'h240}) $display("FAIL dirty_refill got w=%b a=%h expected w=0 a=00000240", tx_write_at(tx_base + 1), tx_addr_at(tx_base + 1)); else pass_cnt++;
    total_cnt++; if (en_rises - rise_base !== 1) $display("FAIL dirty_enable_rises got %0d expected 1", en_rises - rise_base); else pass_cnt++;
    total_cnt++; if (obs_rdata !== exp_rdata) $display("FAIL dirty_rdata got %h expected %h", obs_rdata, exp_rdata); else pass_cnt++;
  endtask

  task automatic test_store_miss();
    logic [255:0] wb;
    model_access(1'b1, 32'h460, 32'h1234_5678);
    issue(1'b0, 1'b1, 32'h460, 32'h1234_5678);
    total_cnt++; if (obs_stall !== 13) $display("FAIL stmiss_stall got %0d expected 13", obs_stall); else pass_cnt++;
    total_cnt++; if ({tx_write_at(tx_base), tx_addr_at(tx_base)} !== {1'b0, 32'h460}) $display("FAIL stmiss_refill got w=%b a=%h expected w=0 a=00000460", tx_write_at(tx_base), tx_addr_at(tx_base)); else pass_cnt++;
    model_access(1'b0, 32'h060, 32'h0);
    issue(1'b1, 1'b0, 32'h060, 32'h0);
    wb = tx_data_at(tx_base);
    total_cnt++; if (obs_stall !== 24) $display("FAIL stmiss_conflict_stall got %0d expected 24", obs_stall); else pass_cnt++;
    total_cnt++; if ({tx_write_at(tx_base), tx_addr_at(tx_base)} !== {1'b1, 32'h460}) $display("FAIL stmiss_wb_addr got w=%b a=%h expected w=1 a=00000460", tx_write_at(tx_base), tx_addr_at(tx_base)); else pass_cnt++;
    total_cnt++; if (wb[31:0] !== 32'h1234_5678) $display("FAIL stmiss_wb_word0 got %h expected 12345678", wb[31:0]); else pass_cnt++;
    total_cnt++; if (obs_rdata !== exp_rdata) $display("FAIL stmiss_rdata got %h expected %h", obs_rdata, exp_rdata); else pass_cnt++;
  endtask

  task automatic test_read_write_both();
    model_access(1'b1, 32'h64, 32'hCAFE_F00D);
    issue(1'b1, 1'b1, 32'h64, 32'hCAFE_F00D);
    total_cnt++; if (obs_stall !== 0 || obs_rdata !== 32'h0) $display("FAIL both_hit got stall=%0d data=%h expected 0 0", obs_stall, obs_rdata); else pass_cnt++;
    model_access(1'b0, 32'h64, 32'h0);
    issue(1'b1, 1'b0, 32'h64, 32'h0);
    total_cnt++; if (obs_rdata !== 32'hCAFE_F00D) $display("FAIL both_reload got %h expected cafef00d", obs_rdata); else pass_cnt++;
    model_access(1'b0, 32'h60, 32'h0);
    issue(1'b1, 1'b0, 32'h60, 32'h0);
    total_cnt++; if (obs_rdata !== exp_rdata) $display("FAIL both_neighbour got %h expected %h", obs_rdata, exp_rdata); else pass_cnt++;
  endtask

  task automatic test_random();
    for (int n = 0; n < 80; n++) begin
      logic [31:0] a;
      logic [31:0] d;
      int          op;
      int          ntx;
      a  = ($urandom_range(0, 3) << 9) | ($urandom_range(0, 15) << 5) | ($urandom_range(0, 7) << 2);
      d  = $urandom;
      op = $urandom_range(0, 2);
      model_access(op != 0, a, d);
      issue(op != 1, op != 0, a, d);
      ntx = tx_a.size() - tx_base;
      total_cnt++; if (obs_stall !== exp_stall) $display("FAIL rand_stall op=%0d addr=%h got %0d expected %0d", n, a, obs_stall, exp_stall); else pass_cnt++;
      total_cnt++; if (obs_rdata !== exp_rdata) $display("FAIL rand_rdata op=%0d addr=%h got %h expected %h", n, a, obs_rdata, exp_rdata); else pass_cnt++;
      total_cnt++; if (ntx !== exp_ntx) $display("FAIL rand_ntx op=%0d addr=%h got %0d expected %0d", n, a, ntx, exp_ntx); else pass_cnt++;
      if (ntx == exp_ntx && exp_ntx > 0) begin
        total_cnt++;
        if ({tx_write_at(tx_base + ntx - 1), tx_addr_at(tx_base + ntx - 1)} !== {1'b0, a & ~32'h1F})
          $display("FAIL rand_refill op=%0d got w=%b a=%h expected w=0 a=%h", n, tx_write_at(tx_base + ntx - 1), tx_addr_at(tx_base + ntx - 1), a & ~32'h1F);
        else pass_cnt++;
      end
      if (ntx == exp_ntx && exp_ntx == 2) begin
        total_cnt++;
        if ({tx_write_at(tx_base), tx_addr_at(tx_base), tx_data_at(tx_base)} !== {1'b1, exp_vaddr, exp_vline})
          $display("FAIL rand_wb op=%0d got a=%h d=%h expected a=%h d=%h", n, tx_addr_at(tx_base), tx_data_at(tx_base), exp_vaddr, exp_vline);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_reset_mid_refill();
    logic [31:0] a;
    bit          seen;
    a    = 32'h0001_0A00;
    seen = 1'b0;
    @(negedge clk_i);
    cpu_addr_i     = a;
    cpu_MemRead_i  = 1'b1;
    cpu_MemWrite_i = 1'b0;
    for (int i = 0; i < 60; i++) begin
      #1;
      if (mem_enable_o === 1'b1 && mem_write_o === 1'b0) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk_i);
    end
    total_cnt++; if (!seen) $display("FAIL rstmid_reach_refill got no refill request expected one within 60 cycles"); else pass_cnt++;
    repeat (3) @(negedge clk_i);
    #2;
    rst_i = 1'b0;
    #1;
    total_cnt++; if (mem_enable_o !== 1'b0) $display("FAIL rstmid_enable got %b expected 0", mem_enable_o); else pass_cnt++;
    total_cnt++; if (cpu_stall_o !== 1'b0 || cpu_data_o !== 32'h0) $display("FAIL rstmid_cpu got stall=%b data=%h expected 0 0", cpu_stall_o, cpu_data_o); else pass_cnt++;
    cpu_MemRead_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    model_reset();
    model_access(1'b0, a, 32'h0);
    issue(1'b1, 1'b0, a, 32'h0);
    total_cnt++; if (obs_stall !== 13) $display("FAIL rstmid_refetch_stall got %0d expected 13", obs_stall); else pass_cnt++;
    total_cnt++; if ({tx_write_at(tx_base), tx_addr_at(tx_base)} !== {1'b0, a}) $display("FAIL rstmid_refetch_tx got w=%b a=%h expected w=0 a=%h", tx_write_at(tx_base), tx_addr_at(tx_base), a); else pass_cnt++;
    total_cnt++; if (obs_rdata !== exp_rdata) $display("FAIL rstmid_rdata got %h expected %h", obs_rdata, exp_rdata); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_clean_miss();
    test_store_hit();
    test_dirty_miss();
    test_store_miss();
    test_read_write_both();
    test_random();
    test_reset_mid_refill();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- Direct-mapped, write-back, write-allocate L1 data cache between the CPU load/store stage and the 256-bit line-wide data memory.
- Serves 32-bit word accesses on a hit with zero added latency.
- On a miss it stalls the CPU, writes back a dirty victim line if needed, then refills the line through the memory's enable/write/ack handshake.

Parameters:
- INDEX_BITS, 4, log2 of line count (16 lines of 32 bytes = 512 B); tag width = 32-5-INDEX_BITS.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-low
- cpu_addr_i  in  32  byte address; [4:2] word select, [4+INDEX_BITS:5] index, upper bits tag
- cpu_data_i  in  32  store data
- cpu_MemRead_i  in  1  load request
- cpu_MemWrite_i  in  1  store request
- cpu_data_o  out  32  load data
- cpu_stall_o  out  1  request not complete this cycle
- mem_data_i  in  256  refill line from memory
- mem_ack_i  in  1  memory transaction done
- mem_data_o  out  256  write-back line
- mem_addr_o  out  32  line address, [4:0]=0
- mem_enable_o  out  1  memory request
- mem_write_o  out  1  1=write-back, 0=refill

Behaviour:
- Reset (async, rst_i=0):
  - All valid and dirty bits cleared; state IDLE.
  - mem_enable_o, mem_write_o, cpu_stall_o and cpu_data_o are 0; mem_addr_o and mem_data_o are 0.
  - Reset mid-transaction aborts immediately. mem_enable_o drops asynchronously, and any partially handled line stays invalid.
- Request: req = MemRead | MemWrite. If both are asserted, the request is treated as a store. The CPU holds addr, data and req stable while cpu_stall_o=1.
- Hit: valid[index] & tag[index]==addr tag, evaluated only in IDLE.
- cpu_stall_o = req & ~(state==IDLE & hit), combinational.
- Read hit: cpu_data_o = selected word of the line, combinational, same cycle. cpu_data_o is 0 when there is no read hit.
- Write hit: the selected word is replaced with cpu_data_i and dirty[index] is set at the clock edge. The other 7 words are unchanged.
- States:
  - IDLE: on req & ~hit, go to WRITEBACK if valid & dirty, else REFILL.
  - WRITEBACK:
    - Drives mem_enable_o=1, mem_write_o=1, mem_addr_o={victim tag, index, 5'b0}, mem_data_o=victim line.
    - All of these are held stable through the cycle in which mem_ack_i=1.
    - On mem_ack_i, go to REFILL.
  - REFILL:
    - Drives mem_enable_o=1, mem_write_o=0, mem_addr_o={cpu tag, index, 5'b0}.
    - mem_enable_o stays high continuously from WRITEBACK into REFILL. The memory re-samples enable/write in its idle cycle.
    - On mem_ack_i, go to FILL.
  - FILL:
    - mem_enable_o=0. Memory read data is registered by the memory on the ack edge, so mem_data_i is sampled in this cycle, not the ack cycle.
    - At the edge: line=mem_data_i, tag=cpu tag, valid=1, dirty=0. Go to IDLE.
    - In IDLE the access hits; a store-miss writes its word then and sets dirty.
- mem_enable_o is never asserted in IDLE or FILL. It is therefore low for at least one cycle after the final ack, so the memory cannot start a spurious transaction.
- mem_ack_i outside WRITEBACK/REFILL is ignored.
- Latency against the 10-cycle memory, with the miss detected in cycle 0:
  - Clean miss: stall high cycles 0..12, completes in cycle 13.
  - Dirty miss: stall high cycles 0..23, completes in cycle 24.
- No req in IDLE: no state change, no memory activity.

Test Plan:
- Reset, then load 0x0000_0040 (clean miss) with memory line 0x40 word0=0x1111_1111 -> one refill with mem_addr_o=0x40 and mem_write_o=0. Stall is high for exactly 13 cycles, then cpu_data_o=0x1111_1111 with stall low.
- Store 0xDEAD_BEEF to 0x44 after that fill -> no stall and no mem_enable_o. A following load of 0x44 returns 0xDEAD_BEEF and 0x40 still returns 0x1111_1111.
- Load 0x0000_0240, which has the same index, a different tag and a dirty victim -> write-back to mem_addr_o=0x40 with mem_data_o word1=0xDEAD_BEEF. This is followed by a refill from 0x240, and stall is high for exactly 24 cycles.
- Store miss to 0x0000_0460 word0 with data 0x1234_5678 -> refill from 0x460, then word0 is written and dirty is set. A later conflicting access to 0x060 first writes back 0x460 containing 0x1234_5678.
- MemRead and MemWrite both high on a hit -> treated as a store and the line is updated.
- Assert rst_i=0 during a REFILL wait -> mem_enable_o=0 immediately. After release, a load of the same address misses again and refetches.
